// File: rtl/hamming_encoder_tx_if.sv
// Data-side bus of the serial Hamming(7,4) transmitter.
// Handshake: a nibble moves on a rising clk edge where din_valid and din_ready
// are both high; din (and the error-injection fields, when present) must be
// stable while din_valid is high, and din_ready never depends combinationally
// on din_valid.
// Optional error-injection fields exist only with HAMMING_ERR_INJECT_EN.
interface hamming_encoder_tx_if;
    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       s_out;
    logic       frame_start;
    logic       busy;
`ifdef HAMMING_ERR_INJECT_EN
    logic       err_en;
    logic [2:0] err_pos;

    modport master (
        output din, din_valid, err_en, err_pos,
        input  din_ready, s_out, frame_start, busy
    );
    modport slave (
        input  din, din_valid, err_en, err_pos,
        output din_ready, s_out, frame_start, busy
    );
`else
    modport master (
        output din, din_valid,
        input  din_ready, s_out, frame_start, busy
    );
    modport slave (
        input  din, din_valid,
        output din_ready, s_out, frame_start, busy
    );
`endif
endinterface

// File: rtl/hamming_encoder_tx.sv
// Serial Hamming(7,4) transmitter: nibbles arrive on a valid/ready handshake
// into a one-entry holding register, are encoded to c[6:0] =
// {d3,d2,d1,p4,d0,p2,p1} and shifted out MSB first on s_out.
// Build option HAMMING_ERR_INJECT_EN adds per-nibble single-bit error injection.
module hamming_encoder_tx (
    input  logic                  clk,
    input  logic                  reset,
    hamming_encoder_tx_if.slave   bus,
    output logic                  dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic [6:0] shift_word;
    logic       s_out_q;
    logic       frame_start_q;

    logic       hold_full;
    logic [3:0] hold_data;
`ifdef HAMMING_ERR_INJECT_EN
    logic       hold_err_en;
    logic [2:0] hold_err_pos;
`endif

    logic       accept;
    logic       load;
    logic [6:0] load_word;

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Ready depends only on registered state and reset, never on din_valid.
    assign bus.din_ready   = !hold_full && !reset;
    assign accept          = bus.din_valid && bus.din_ready;
    // Held nibble moves to the shifter when idle or on the last bit of a frame.
    assign load            = hold_full && ((state == IDLE) || (cnt == 3'd6));

    assign bus.s_out       = s_out_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = (state == SHIFT) || hold_full;
    assign dbg_state       = (state == SHIFT);

    // Codeword for the held nibble, with the optional single-bit flip applied.
    always_comb begin
        load_word = encode(hold_data);
`ifdef HAMMING_ERR_INJECT_EN
        // Shifting 1 by 7 falls off the 7-bit mask, so err_pos = 7 flips nothing.
        if (hold_err_en) begin
            load_word = load_word ^ (7'd1 << hold_err_pos);
        end
`endif
    end

    // Holding register: capture on handshake, release when loaded into the shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full    <= 1'b0;
            hold_data    <= 4'd0;
`ifdef HAMMING_ERR_INJECT_EN
            hold_err_en  <= 1'b0;
            hold_err_pos <= 3'd7;
`endif
        end else begin
            if (accept) begin
                hold_data    <= bus.din;
`ifdef HAMMING_ERR_INJECT_EN
                hold_err_en  <= bus.err_en;
                hold_err_pos <= bus.err_pos;
`endif
            end
            if (accept) begin
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

    // Transmit FSM with registered serial output and frame marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 3'd0;
            shift_word    <= 7'd0;
            s_out_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    s_out_q       <= 1'b0;
                    frame_start_q <= 1'b0;
                    if (hold_full) begin
                        shift_word <= load_word;
                        cnt        <= 3'd0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    s_out_q       <= shift_word[3'd6 - cnt];
                    frame_start_q <= (cnt == 3'd0);
                    if (cnt == 3'd6) begin
                        cnt <= 3'd0;
                        if (hold_full) begin
                            // Next frame follows the last bit with no idle gap.
                            shift_word <= load_word;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Bench for hamming_encoder_tx: directed scenarios plus randomized traffic,
// checked against a positional Hamming(7,4) model and a serial-stream monitor.
module tb_hamming_encoder_tx;

    logic clk = 1'b0;
    logic reset;
    logic dbg_state;
    int   total = 0;
    int   bad   = 0;

    hamming_encoder_tx_if bus_if();

    hamming_encoder_tx dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if.slave),
        .dbg_state (dbg_state)
    );

    // Clock and overall time limit
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: bit position i (1..7) of the code is c[i-1];
    // data sits at positions 3,5,6,7, parity at 1,2,4 covers positions sharing that bit.
    function automatic logic [6:0] model_encode(input logic [3:0] d, input bit e, input int p);
        logic [7:1] w;
        int dpos[4];
        logic [6:0] cw;
        dpos = '{3, 5, 6, 7};
        w = '0;
        for (int i = 0; i < 4; i++) w[dpos[i]] = d[i];
        for (int k = 0; k < 3; k++) begin
            logic par;
            par = 1'b0;
            for (int pos = 3; pos <= 7; pos++)
                if (((pos >> k) & 1) == 1 && pos != 4) par ^= w[pos];
            w[1 << k] = par;
        end
        cw = w[7:1];
        if (e && p < 7) cw[p] = ~cw[p];
        return cw;
    endfunction

    function automatic logic [3:0] model_decode(input logic [6:0] cw);
        logic [7:1] w;
        int syn;
        w = cw;
        syn = 0;
        for (int pos = 1; pos <= 7; pos++) if (w[pos]) syn ^= pos;
        if (syn != 0) w[syn] = ~w[syn];
        return {w[7], w[6], w[5], w[3]};
    endfunction

    // Scoreboard: expected codewords in transfer order, observed codewords
    logic [6:0] exp_q[$];
    logic [6:0] rx_q[$];
    int         bit_idx = 7;
    logic [6:0] cur_exp = '0;
    logic [6:0] obs_cw = '0;
    bit         mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_if.frame_start) begin
                total++;
                if (bit_idx != 7 || exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL mon_frame_start: start at bit_idx=%0d queued=%0d, required bit_idx=7 queued>0",
                             bit_idx, exp_q.size());
                end
                if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
                bit_idx = 6;
            end
            if (bit_idx != 7) begin
                total++;
                if (bus_if.s_out !== cur_exp[bit_idx]) begin
                    bad++;
                    $display("FAIL mon_bit: c[%0d] got %b required %b (codeword %b)",
                             bit_idx, bus_if.s_out, cur_exp[bit_idx], cur_exp);
                end
                obs_cw[bit_idx] = bus_if.s_out;
                if (bit_idx == 0) begin
                    rx_q.push_back(obs_cw);
                    bit_idx = 7;
                end else begin
                    bit_idx--;
                end
            end else begin
                total++;
                if (bus_if.s_out !== 1'b0) begin
                    bad++;
                    $display("FAIL mon_idle: s_out got %b required 0 between frames", bus_if.s_out);
                end
            end
        end
    end

    // Driver: present a nibble and wait for the handshake edge
    task automatic send(input logic [3:0] d, input bit e, input logic [2:0] p);
        int n;
        bus_if.din       = d;
`ifdef HAMMING_ERR_INJECT_EN
        bus_if.err_en    = e;
        bus_if.err_pos   = p;
`endif
        bus_if.din_valid = 1'b1;
        n = 0;
        while (!bus_if.din_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!bus_if.din_ready) begin
            bad++;
            $display("FAIL send_timeout: din_ready got 0 after %0d cycles required 1", n);
        end
        @(posedge clk);
`ifdef HAMMING_ERR_INJECT_EN
        exp_q.push_back(model_encode(d, e, int'(p)));
`else
        exp_q.push_back(model_encode(d, 1'b0, 7));
`endif
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bit_idx != 7 || bus_if.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL drain_timeout: queued=%0d busy=%b required queue empty and idle",
                     exp_q.size(), bus_if.busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total += 4;
        if (bus_if.s_out !== 1'b0)       begin bad++; $display("FAIL rst_s_out: got %b required 0", bus_if.s_out); end
        if (bus_if.frame_start !== 1'b0) begin bad++; $display("FAIL rst_frame_start: got %b required 0", bus_if.frame_start); end
        if (bus_if.busy !== 1'b0)        begin bad++; $display("FAIL rst_busy: got %b required 0", bus_if.busy); end
        if (bus_if.din_ready !== 1'b0)   begin bad++; $display("FAIL rst_ready_in_reset: got %b required 0", bus_if.din_ready); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total += 2;
        if (bus_if.din_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b required 1", bus_if.din_ready); end
        if (bus_if.busy !== 1'b0)      begin bad++; $display("FAIL rst_busy_after: got %b required 0", bus_if.busy); end
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        logic [6:0] pat;
        pat = 7'b1010101;
        @(negedge clk);
        send(4'b1011, 1'b0, 3'd7);
        bus_if.din_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus_if.busy !== 1'b1) begin bad++; $display("FAIL single_busy_e0: got %b required 1", bus_if.busy); end
        @(negedge clk);
        total++;
        if (bus_if.s_out !== 1'b0 || bus_if.frame_start !== 1'b0) begin
            bad++;
            $display("FAIL single_e1: s_out=%b frame_start=%b required 0 0", bus_if.s_out, bus_if.frame_start);
        end
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            total += 2;
            if (bus_if.s_out !== pat[6-k]) begin
                bad++; $display("FAIL single_bit: cycle E+%0d got %b required %b", k + 2, bus_if.s_out, pat[6-k]);
            end
            if (bus_if.frame_start !== (k == 0)) begin
                bad++; $display("FAIL single_frame_start: cycle E+%0d got %b required %b", k + 2, bus_if.frame_start, (k == 0));
            end
        end
        @(negedge clk);
        total += 2;
        if (bus_if.busy !== 1'b0)  begin bad++; $display("FAIL single_busy_e9: got %b required 0", bus_if.busy); end
        if (bus_if.s_out !== 1'b0) begin bad++; $display("FAIL single_s_out_e9: got %b required 0", bus_if.s_out); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [13:0] bits;
        send(4'b0000, 1'b0, 3'd7);
        send(4'b1111, 1'b0, 3'd7);
        bus_if.din_valid = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            bits[13-k] = bus_if.s_out;
            total++;
            if (bus_if.frame_start !== (k == 0 || k == 7)) begin
                bad++; $display("FAIL b2b_frame_start: bit %0d got %b required %b", k, bus_if.frame_start, (k == 0 || k == 7));
            end
            if (k < 6) begin
                total += 2;
                if (bus_if.din_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready: bit %0d got %b required 0", k, bus_if.din_ready); end
                if (bus_if.busy !== 1'b1)      begin bad++; $display("FAIL b2b_busy: bit %0d got %b required 1", k, bus_if.busy); end
            end
        end
        total++;
        if (bits !== 14'b00000001111111) begin
            bad++; $display("FAIL b2b_stream: got %b required %b", bits, 14'b00000001111111);
        end
        drain();
    endtask

    task automatic test_ignored_valid();
        logic [6:0] obs;
        send(4'b0001, 1'b0, 3'd7);
        send(4'b0110, 1'b0, 3'd7);
        bus_if.din_valid = 1'b0;
        @(negedge clk);
        obs[6] = bus_if.s_out;
        total++;
        if (bus_if.din_ready !== 1'b0) begin bad++; $display("FAIL ign_ready: got %b required 0", bus_if.din_ready); end
        bus_if.din       = 4'b1001;
        bus_if.din_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.din_valid = 1'b0;
        for (int k = 1; k < 7; k++) begin
            @(negedge clk);
            obs[6-k] = bus_if.s_out;
        end
        total++;
        if (obs !== 7'b0000111) begin bad++; $display("FAIL ign_codeword: got %b required 0000111", obs); end
        drain();
    endtask

    task automatic test_reset_mid_frame();
        mon_en = 1'b0;
        send(4'b1100, 1'b0, 3'd7);
        send(4'b0101, 1'b0, 3'd7);
        bus_if.din_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total += 4;
        if (bus_if.s_out !== 1'b0)       begin bad++; $display("FAIL midrst_s_out: got %b required 0", bus_if.s_out); end
        if (bus_if.busy !== 1'b0)        begin bad++; $display("FAIL midrst_busy: got %b required 0", bus_if.busy); end
        if (bus_if.frame_start !== 1'b0) begin bad++; $display("FAIL midrst_frame_start: got %b required 0", bus_if.frame_start); end
        if (bus_if.din_ready !== 1'b0)   begin bad++; $display("FAIL midrst_ready_in_reset: got %b required 0", bus_if.din_ready); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus_if.din_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_after: got %b required 1", bus_if.din_ready); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total++;
            if (bus_if.s_out !== 1'b0 || bus_if.frame_start !== 1'b0 || bus_if.busy !== 1'b0) begin
                bad++;
                $display("FAIL midrst_quiet: cycle %0d s_out=%b frame_start=%b busy=%b required 0 0 0",
                         k, bus_if.s_out, bus_if.frame_start, bus_if.busy);
            end
        end
        exp_q.delete();
        bit_idx = 7;
        mon_en  = 1'b1;
    endtask

`ifdef HAMMING_ERR_INJECT_EN
    task automatic test_err_inject();
        logic [6:0] obs;
        logic [2:0] pos_list[2];
        logic [6:0] want[2];
        pos_list = '{3'd2, 3'd7};
        want     = '{7'b1010001, 7'b1010101};
        for (int t = 0; t < 2; t++) begin
            send(4'b1011, 1'b1, pos_list[t]);
            bus_if.din_valid = 1'b0;
            repeat (2) @(negedge clk);
            for (int k = 0; k < 7; k++) begin
                obs[6-k] = bus_if.s_out;
                @(negedge clk);
            end
            total++;
            if (obs !== want[t]) begin
                bad++; $display("FAIL err_inject: err_pos=%0d got %b required %b", pos_list[t], obs, want[t]);
            end
            drain();
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [3:0] d;
            logic [2:0] p;
            bit e;
            int g;
            d = 4'($urandom_range(0, 15));
            e = 1'($urandom_range(0, 1));
            p = 3'($urandom_range(0, 7));
`ifndef HAMMING_ERR_INJECT_EN
            e = 1'b0;
`endif
            send(d, e, p);
            g = $urandom_range(0, 3);
            if (g > 0) begin
                bus_if.din_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
        end
        bus_if.din_valid = 1'b0;
        drain();
    endtask

    task automatic test_loopback();
        int rounds;
`ifdef HAMMING_ERR_INJECT_EN
        rounds = 2;
`else
        rounds = 1;
`endif
        for (int r = 0; r < rounds; r++) begin
            rx_q.delete();
            for (int i = 0; i < 16; i++) begin
                send(4'(i), (r == 1), 3'($urandom_range(0, 6)));
            end
            bus_if.din_valid = 1'b0;
            drain();
            total++;
            if (rx_q.size() != 16) begin
                bad++; $display("FAIL loop_count: round %0d got %0d frames required 16", r, rx_q.size());
            end
            for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
                total++;
                if (model_decode(rx_q[i]) !== 4'(i)) begin
                    bad++;
                    $display("FAIL loop_decode: round %0d frame %0d codeword %b decoded %h required %h",
                             r, i, rx_q[i], model_decode(rx_q[i]), 4'(i));
                end
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus_if.din       = 4'd0;
        bus_if.din_valid = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
        bus_if.err_en    = 1'b0;
        bus_if.err_pos   = 3'd7;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored_valid();
        test_reset_mid_frame();
`ifdef HAMMING_ERR_INJECT_EN
        test_err_inject();
`endif
        test_random();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
